// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the reg_pipe elastic pipeline register.
// Provides clog2, which sizes the occupancy counter.
package reg_pipe_pkg;

    // Ceiling log2. A value of n needs clog2(n) bits to hold 0..n-1, so
    // clog2(Depth+1) bits hold an occupancy count of 0..Depth.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One stage of the elastic pipeline: a data register plus its valid bit.
// Ports:
//   clock, reset    rising-edge clock, async active-low reset
//   flush           synchronous clear of the valid bit (data is kept)
//   load            capture data_i/valid_i this edge
//   data_i, valid_i incoming beat (from upstream or the previous stage)
//   data_o, valid_o registered beat
module reg_pipe_stage #(
    parameter int Size = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic [Size-1:0] data_i,
    input  logic            valid_i,
    output logic [Size-1:0] data_o,
    output logic            valid_o
);

    logic [Size-1:0] data_q, data_d;
    logic            v_q, v_d;

    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        if (flush) begin
            // Flush wins over any load; only the valid bit is cleared.
            v_d = 1'b0;
        end else if (load) begin
            // Bubbles load too: data is don't-care when v_d is 0.
            data_d = data_i;
            v_d    = valid_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = v_q;

endmodule

// File: rtl/reg_pipe.sv
// Elastic pipeline register: Depth stages of Size-bit data with per-stage
// valid bits, valid/ready handshake, back-pressure with compaction toward
// the output, synchronous flush and a registered occupancy count.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   data_i, valid_i   upstream beat; ready_o says it is accepted this cycle
//   data_o, valid_o   last-stage beat; ready_i says downstream takes it
//   flush             synchronous clear of every stage's valid bit
//   count_o           number of valid stages (0..Depth)
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int Size  = 8,
    parameter int Depth = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [Size-1:0]               data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [Size-1:0]               data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    input  logic                          flush,
    output logic [clog2(Depth+1)-1:0]     count_o
);

    localparam int CountW = clog2(Depth + 1);

    logic [Depth-1:0][Size-1:0] stage_data;
    logic [Depth-1:0]           stage_v;
    logic [Depth:0]             adv;

    // A stage may advance if it is empty or the stage after it advances.
    // The chain is combinational end to end so a full pipe can still take
    // a beat in the same cycle one leaves.
    always_comb begin
        adv        = '0;
        adv[Depth] = ready_i;
        for (int k = Depth - 1; k >= 0; k--) begin
            adv[k] = !stage_v[k] | adv[k+1];
        end
    end

    assign ready_o = adv[0] & !flush;

    for (genvar k = 0; k < Depth; k++) begin : g_stage
        logic [Size-1:0] src_data;
        logic            src_v;

        if (k == 0) begin : g_head
            assign src_data = data_i;
            assign src_v    = valid_i;
        end else begin : g_body
            assign src_data = stage_data[k-1];
            assign src_v    = stage_v[k-1];
        end

        reg_pipe_stage #(.Size(Size)) u_stage (
            .clock   (clock),
            .reset   (reset),
            .flush   (flush),
            .load    (adv[k]),
            .data_i  (src_data),
            .valid_i (src_v),
            .data_o  (stage_data[k]),
            .valid_o (stage_v[k])
        );
    end

    assign data_o  = stage_data[Depth-1];
    assign valid_o = stage_v[Depth-1];

    // Occupancy tracks the valid bits: +1 per accepted beat, -1 per
    // completed output transfer, cleared by flush.
    logic              acc_in, xfer_out;
    logic [CountW-1:0] count_q, count_d;

    assign acc_in   = valid_i & ready_o;
    assign xfer_out = valid_o & ready_i;

    always_comb begin
        count_d = count_q + CountW'(acc_in) - CountW'(xfer_out);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: a Depth=3/Size=8 instance for directed
// scenarios and a Depth=1/Size=16 instance for a random handshake run.
// Stimulus pushes each accepted beat into a queue; monitors pop and compare
// on every output transfer.
module tb_reg_pipe;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0]  data_i3, data_o3;
    logic        valid_i3, ready_o3, valid_o3, ready_i3, flush3;
    logic [1:0]  count_o3;

    logic [15:0] data_i1, data_o1;
    logic        valid_i1, ready_o1, valid_o1, ready_i1, flush1;
    logic [0:0]  count_o1;

    reg_pipe #(.Size(8), .Depth(3)) u_d3 (
        .clock(clock), .reset(reset), .data_i(data_i3), .valid_i(valid_i3),
        .ready_o(ready_o3), .data_o(data_o3), .valid_o(valid_o3),
        .ready_i(ready_i3), .flush(flush3), .count_o(count_o3)
    );

    reg_pipe #(.Size(16), .Depth(1)) u_d1 (
        .clock(clock), .reset(reset), .data_i(data_i1), .valid_i(valid_i1),
        .ready_o(ready_o1), .data_o(data_o1), .valid_o(valid_o1),
        .ready_i(ready_i1), .flush(flush1), .count_o(count_o1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0]  q3[$];
    logic [15:0] q1[$];
    logic        fl3_prev = 1'b0;
    int          acc01   = -1;
    int          first01 = -1;
    int          last_x3 = -1;
    int          prev_x3 = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output monitors: pop the expected beat on each transfer.
    always @(negedge clock) begin
        if (reset) begin
            chk("cnt3_popcount", 32'(count_o3), 32'($countones(u_d3.stage_v)));
            chk("cnt1_popcount", 32'(count_o1), 32'($countones(u_d1.stage_v)));
            if (valid_o3 && ready_i3) begin
                if (q3.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out3_unexpected: got %0h expected no beat", data_o3);
                end else begin
                    chk("out3_data", 32'(data_o3), 32'(q3.pop_front()));
                end
                if (data_o3 == 8'h01 && first01 < 0) first01 = cyc;
                prev_x3 = last_x3;
                last_x3 = cyc;
            end
            if (valid_o1 && ready_i1) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out1_unexpected: got %0h expected no beat", data_o1);
                end else begin
                    chk("out1_data", 32'(data_o1), 32'(q1.pop_front()));
                end
            end
        end
    end

    // One cycle on the Depth=3 instance: check occupancy and ready against
    // the scoreboard, then drive inputs and record an accepted beat.
    task automatic drive3(input logic v, input logic [7:0] d, input logic r, input logic f);
        @(posedge clock);
        if (fl3_prev) q3.delete();
        #1;
        chk("count3", 32'(count_o3), 32'(q3.size()));
        valid_i3 = v; data_i3 = d; ready_i3 = r; flush3 = f;
        #1;
        chk("ready3", 32'(ready_o3), 32'(((q3.size() < 3) || r) && !f));
        if (v && ready_o3) begin
            q3.push_back(d);
            if (d == 8'h01 && acc01 < 0) acc01 = cyc;
        end
        fl3_prev = f;
    endtask

    task automatic drive1(input logic v, input logic [15:0] d, input logic r);
        @(posedge clock);
        #1;
        chk("count1", 32'(count_o1), 32'(q1.size()));
        valid_i1 = v; data_i1 = d; ready_i1 = r;
        #1;
        chk("ready1", 32'(ready_o1), 32'((q1.size() < 1) || r));
        if (v && ready_o1) q1.push_back(d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        valid_i3 = 0; data_i3 = 0; ready_i3 = 0; flush3 = 0;
        valid_i1 = 0; data_i1 = 0; ready_i1 = 0; flush1 = 0;
        #2;
        chk("rst_valid3", 32'(valid_o3), 0);
        chk("rst_count3", 32'(count_o3), 0);
        chk("rst_data3",  32'(data_o3),  0);
        chk("rst_valid1", 32'(valid_o1), 0);
        #10 reset = 1'b1;
        #1 chk("rst_ready3", 32'(ready_o3), 1);

        // Reset mid-stream: 0x11 reaches the output, then async reset.
        drive3(1, 8'h11, 0, 0);
        drive3(1, 8'h22, 0, 0);
        drive3(0, 8'h00, 0, 0);
        drive3(0, 8'h00, 0, 0);
        chk("mid_valid_before", 32'(valid_o3), 1);
        chk("mid_data_before",  32'(data_o3),  32'h11);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o3), 0);
        chk("mid_rst_count", 32'(count_o3), 0);
        chk("mid_rst_data",  32'(data_o3),  0);
        q3.delete();
        #2 reset = 1'b1;
        #1 chk("mid_rst_ready", 32'(ready_o3), 1);

        // Latency and throughput.
        for (int i = 1; i <= 8; i++) drive3(1, 8'(i), 1, 0);
        for (int i = 0; i < 4; i++) drive3(0, 8'h00, 1, 0);
        chk("latency",   32'(first01 - acc01), 3);
        chk("no_bubble", 32'(last_x3 - first01), 7);

        // Back-pressure and compaction.
        drive3(1, 8'hA0, 0, 0);
        drive3(1, 8'hA1, 0, 0);
        drive3(1, 8'hA2, 0, 0);
        drive3(1, 8'hA3, 0, 0);
        chk("bp_ready", 32'(ready_o3), 0);
        chk("bp_count", 32'(count_o3), 3);
        chk("bp_data",  32'(data_o3),  32'hA0);
        drive3(1, 8'hA3, 0, 0);
        chk("bp_hold_data",  32'(data_o3),  32'hA0);
        chk("bp_hold_valid", 32'(valid_o3), 1);
        drive3(1, 8'hA3, 1, 0);
        chk("bp_full_ready", 32'(ready_o3), 1);
        drive3(0, 8'h00, 0, 0);
        chk("bp_count_kept", 32'(count_o3), 3);
        chk("bp_next_data",  32'(data_o3),  32'hA1);
        for (int i = 0; i < 4; i++) drive3(0, 8'h00, 1, 0);

        // Flush priority.
        drive3(1, 8'hC0, 0, 0);
        drive3(1, 8'hC1, 0, 0);
        drive3(1, 8'hEE, 0, 1);
        chk("fl_ready", 32'(ready_o3), 0);
        drive3(1, 8'h55, 1, 0);
        chk("fl_count", 32'(count_o3), 0);
        chk("fl_valid", 32'(valid_o3), 0);
        for (int i = 0; i < 4; i++) drive3(0, 8'h00, 1, 0);
        chk("fl_next_out", 32'(last_x3 >= 0), 1);

        // Bubbles.
        drive3(1, 8'hB0, 1, 0);
        chk("bub_cnt_a", 32'(count_o3 <= 2), 1);
        drive3(0, 8'h00, 1, 0);
        chk("bub_cnt_b", 32'(count_o3 <= 2), 1);
        drive3(1, 8'hB1, 1, 0);
        chk("bub_cnt_c", 32'(count_o3 <= 2), 1);
        drive3(0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive3(0, 8'h00, 1, 0);
            chk("bub_cnt_d", 32'(count_o3 <= 2), 1);
        end
        chk("bub_gap", 32'(last_x3 - prev_x3), 2);
        chk("q3_drained", 32'(q3.size()), 0);

        // Depth=1 random handshake.
        for (int i = 0; i < 1000; i++) begin
            drive1(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) drive1(0, 16'h0, 1);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised elastic pipeline register: Depth stages of Size-bit data, each stage with its own valid bit.
- Successor to the plain enable-register: adds a valid/ready handshake, back-pressure, synchronous flush and an occupancy count.
- Placed between producer/consumer blocks to break timing paths.
- Sustains one beat per cycle.

Parameters:
- Size, 8, data width in bits (>=1).
- Depth, 2, number of register stages (>=1).
- CountW, derived as $clog2(Depth+1), width of count_o; not overridable.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- data_i  input  Size  upstream data.
- valid_i  input  1  upstream beat valid.
- ready_o  output  1  block accepts a beat this cycle.
- data_o  output  Size  data of the last stage.
- valid_o  output  1  last stage holds a valid beat.
- ready_i  input  1  downstream accepts this cycle.
- flush  input  1  synchronous clear of all stages.
- count_o  output  CountW  number of valid stages (0..Depth).

Behaviour:
- Storage:
  - Stage k (0 = input side, Depth-1 = output side) has data_q[k] (Size bits) and v_q[k] (1 bit).
  - data_o = data_q[Depth-1]; valid_o = v_q[Depth-1].
- Reset (reset=0, asynchronous, any time, including mid-transfer):
  - All v_q and data_q go to 0 immediately, so valid_o=0, data_o=0, count_o=0.
  - ready_o=1 once reset deasserts, provided flush=0.
- Advance chain (combinational):
  - adv[Depth] = ready_i.
  - adv[k] = !v_q[k] | adv[k+1].
  - ready_o = adv[0] & !flush.
  - The ready path is combinational through all stages, by design.
- Per rising edge, no flush:
  - Stage 0 loads data_i/valid_i when adv[0]. A beat is accepted only if valid_i & ready_o.
  - Stage k>0 loads data_q[k-1]/v_q[k-1] when adv[k].
  - When a stage loads a bubble (source v=0), v_q clears. data_q is don't-care but loads anyway; no separate hold logic.
  - A stage with adv[k]=0 holds data and valid.
- Transfer out occurs on valid_o & ready_i.
- Latency: a beat accepted into an empty pipe with ready_i=1 appears on valid_o exactly Depth cycles after acceptance.
- Throughput: 1 beat/cycle sustained while ready_i=1.
- Back-pressure: with ready_i=0, stages compact toward the output until all Depth are full; then ready_o=0.
  - Full pipe + ready_i=1: ready_o=1 in the same cycle, so simultaneous in/out keeps count at Depth.
- Stability: while valid_o=1 & ready_i=0, data_o and valid_o are held unchanged.
- Flush (flush=1 at an edge):
  - All v_q clear; data_q is unchanged.
  - ready_o=0 while flush=1, so no input beat is accepted or lost.
  - An output transfer coinciding with flush still counts as completed downstream.
  - Flush takes priority over every load.
- count_o: registered popcount of v_q, updated in the same edge as v_q.
  - Next value = count + accepted_in - transferred_out, or 0 on flush.
  - Must always equal popcount(v_q); this is a bench assertion.
- Depth=1: single stage. ready_o = (!v_q[0] | ready_i) & !flush.

Decomposition:
- Shared package: the clog2 helper function used to derive CountW.
- No typedefs needed.
- One natural sub-module: reg_pipe_stage.
  - Ports: clock, reset, flush, load, data_i, valid_i, data_o, valid_o.
  - Instantiated Depth times in a generate loop.
- The parent holds the adv chain and the counter.

Test Plan:
- Reset mid-stream: Depth=3, fill with 0x11,0x22 then drive reset=0 between edges → valid_o/count_o drop to 0 immediately, without waiting for a clock edge; after release, ready_o=1.
- Latency/throughput: Depth=3, ready_i=1, stream 0x01..0x08 back-to-back → 0x01 on valid_o 3 cycles after acceptance, then one beat per cycle in order, no bubbles.
- Back-pressure: ready_i=0, offer 0xA0,0xA1,0xA2,0xA3 → first three accepted, count_o=3, ready_o=0, data_o=0xA0 held stable.
  - Then raise ready_i for one cycle → 0xA0 out and 0xA3 accepted in the same edge; count_o remains 3.
- Flush priority: pipe holds 2 beats, assert flush with valid_i=1 → ready_o=0, next cycle count_o=0 and valid_o=0, input beat not accepted; resume with 0x55 → it is the next output.
- Bubbles: valid_i toggling 1,0,1,0 with data 0xB0,xx,0xB1,xx, ready_i=1 → outputs 0xB0 then 0xB1 with one idle cycle between them; count_o never exceeds 2.
- Depth=1, Size=16: random valid_i/ready_i for 1000 cycles against a reference queue → in-order, no loss or duplication; count_o ∈ {0,1}.
